// File: rtl/timer_mmio_responder.sv
// Down-counting timer on the Timer I/O window: CTRL/LOAD/COUNT/STATUS/PRESCALE registers,
// prescaled tick, one-shot or auto-reload expiry, and a level interrupt.
module timer_mmio_responder #(
    parameter int unsigned PRESC_W = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memWrite_Timer,
    input  logic [31:0] io_addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {Idle, Run, Done} stateT;

    stateT              state;
    logic [2:0]         ctrlReg;
    logic [CNT_W-1:0]   loadReg;
    logic [CNT_W-1:0]   countReg;
    logic [PRESC_W-1:0] prescaleReg;
    logic [PRESC_W-1:0] presCnt;
    logic               expFlag;

    logic [5:0] regSel;
    logic       ctrlWr, loadWr, statWr, preWr;
    logic       tick;
    logic       unusedBits;

    assign regSel = io_addr[7:2];
    assign ctrlWr = memWrite_Timer && (regSel == 6'd0);
    assign loadWr = memWrite_Timer && (regSel == 6'd1);
    assign statWr = memWrite_Timer && (regSel == 6'd3);
    assign preWr  = memWrite_Timer && (regSel == 6'd4);
    assign tick   = (state == Run) && (presCnt == prescaleReg);
    assign unusedBits = ^{io_addr[31:8], io_addr[1:0], wdata};

    always_comb begin
        rdata = '0;
        case (regSel)
            6'd0:    rdata = {29'd0, ctrlReg};
            6'd1:    rdata = 32'(loadReg);
            6'd2:    rdata = 32'(countReg);
            6'd3:    rdata = {31'd0, expFlag};
            6'd4:    rdata = 32'(prescaleReg);
            default: rdata = '0;
        endcase
    end

    assign irq = expFlag & ctrlReg[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= Idle;
            ctrlReg     <= '0;
            loadReg     <= '0;
            countReg    <= '0;
            prescaleReg <= '0;
            presCnt     <= '0;
            expFlag     <= 1'b0;
        end else begin
            if (ctrlWr) ctrlReg <= wdata[2:0];
            if (loadWr) loadReg <= wdata[CNT_W-1:0];
            if (preWr) prescaleReg <= wdata[PRESC_W-1:0];
            if (statWr && wdata[0]) expFlag <= 1'b0;

            case (state)
                Idle, Done: begin
                    if (ctrlWr && wdata[0]) begin
                        countReg <= loadReg;
                        presCnt  <= '0;
                        state    <= Run;
                    end
                end
                Run: begin
                    // Stopping freezes COUNT and the prescaler, ignoring any tick this cycle.
                    if (ctrlWr && !wdata[0]) begin
                        state <= Idle;
                    end else begin
                        if (tick || preWr) presCnt <= '0;
                        else               presCnt <= presCnt + PRESC_W'(1);
                        if (tick) begin
                            if (countReg != '0) begin
                                countReg <= countReg - CNT_W'(1);
                            end else begin
                                // Placed after the W1C above so a same-cycle expiry wins.
                                expFlag <= 1'b1;
                                if (ctrlReg[1]) begin
                                    countReg <= loadReg;
                                end else if (!ctrlWr) begin
                                    ctrlReg[0] <= 1'b0;
                                    state      <= Done;
                                end
                            end
                        end
                    end
                end
                default: state <= Idle;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_mmio_responder.sv
// Bench for timer_mmio_responder: directed scenarios plus randomized bus traffic checked
// against a register-level model of the timer.
module tb_timer_mmio_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        memWrite_Timer = 1'b0;
    logic [31:0] io_addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        irq;

    int total = 0;
    int bad = 0;

    // Model: the timer runs exactly when EN is set; mPhase is clocks elapsed in the current tick.
    logic [2:0]  mCtrl;
    logic [31:0] mLoad, mCount;
    logic [15:0] mPre;
    logic        mExp;
    int unsigned mPhase;

    timer_mmio_responder #(.PRESC_W(16), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .memWrite_Timer(memWrite_Timer),
        .io_addr(io_addr), .wdata(wdata), .rdata(rdata), .irq(irq)
    );

    always #10 clk = ~clk;

    function automatic logic [31:0] mRead(input logic [31:0] a);
        case (a[7:2])
            6'd0:    return {29'd0, mCtrl};
            6'd1:    return mLoad;
            6'd2:    return mCount;
            6'd3:    return {31'd0, mExp};
            6'd4:    return {16'd0, mPre};
            default: return 32'd0;
        endcase
    endfunction

    task automatic modelReset();
        mCtrl = '0; mLoad = '0; mCount = '0; mPre = '0; mExp = 1'b0; mPhase = 0;
    endtask

    task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d);
        logic [2:0]  oCtrl;
        logic [31:0] oLoad;
        logic [15:0] oPre;
        logic [5:0]  sel;
        logic        ctrlWr, tick;
        oCtrl = mCtrl; oLoad = mLoad; oPre = mPre; sel = a[7:2];
        ctrlWr = we && (sel == 6'd0);
        if (we) begin
            case (sel)
                6'd0: mCtrl = d[2:0];
                6'd1: mLoad = d;
                6'd3: if (d[0]) mExp = 1'b0;
                6'd4: mPre = d[15:0];
                default: ;
            endcase
        end
        if (!oCtrl[0]) begin
            if (ctrlWr && d[0]) begin
                mCount = oLoad;
                mPhase = 0;
            end
        end else if (!(ctrlWr && !d[0])) begin
            tick = (mPhase == oPre);
            mPhase = (tick || (we && sel == 6'd4)) ? 0 : mPhase + 1;
            if (tick) begin
                if (mCount > 0) mCount = mCount - 1;
                else begin
                    mExp = 1'b1;
                    if (oCtrl[1]) mCount = oLoad;
                    else if (!ctrlWr) mCtrl[0] = 1'b0;
                end
            end
        end
    endtask

    // One clock with the given bus cycle; returns 1 time unit after the rising edge.
    task automatic clk1(input logic we, input logic [31:0] a, input logic [31:0] d);
        memWrite_Timer = we; io_addr = a; wdata = d;
        @(posedge clk);
        step(we, a, d);
        #1;
        memWrite_Timer = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] a;
        modelReset();
        #2;
        for (int i = 0; i < 5; i++) begin
            a = 32'(i * 4);
            io_addr = a; #1;
            total++;
            if (rdata !== 32'd0) begin
                bad++; $display("FAIL reset_reg[%0h]: got %0h want 0", a, rdata);
            end
        end
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq); end
        #1 rst_n = 1'b1;
    endtask

    task automatic test_oneshot();
        clk1(1, 32'h04, 32'd3);
        clk1(1, 32'h10, 32'd0);
        clk1(1, 32'h00, 32'h5);
        io_addr = 32'h08; #1;
        total++;
        if (rdata !== 32'd3) begin bad++; $display("FAIL oneshot_start: got %0d want 3", rdata); end
        for (int i = 1; i <= 3; i++) begin
            clk1(0, 32'h08, 32'd0);
            total++;
            if (rdata !== 32'(3 - i)) begin
                bad++; $display("FAIL oneshot_count%0d: got %0d want %0d", i, rdata, 3 - i);
            end
        end
        clk1(0, 32'h08, 32'd0);
        total++;
        if (irq !== 1'b1) begin bad++; $display("FAIL oneshot_irq: got %b want 1", irq); end
        io_addr = 32'h00; #1;
        total++;
        if (rdata !== 32'h4) begin bad++; $display("FAIL oneshot_ctrl: got %0h want 4", rdata); end
        clk1(0, 32'h08, 32'd0);
        clk1(0, 32'h08, 32'd0);
        total++;
        if (rdata !== 32'd0) begin bad++; $display("FAIL oneshot_hold: got %0d want 0", rdata); end
        clk1(1, 32'h0C, 32'h1);
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL oneshot_clear: got %b want 0", irq); end
    endtask

    task automatic test_autoreload();
        logic want;
        clk1(1, 32'h04, 32'd2);
        clk1(1, 32'h10, 32'd1);
        clk1(1, 32'h00, 32'h3);
        for (int k = 1; k <= 12; k++) begin
            if (k == 7) clk1(1, 32'h0C, 32'h1);
            else        clk1(0, 32'h0C, 32'h0);
            want = (k == 6) || (k == 12);
            total++;
            if (rdata !== {31'd0, want}) begin
                bad++; $display("FAIL autoreload_exp@%0d: got %0d want %0d", k, rdata, want);
            end
        end
        io_addr = 32'h08; #1;
        total++;
        if (rdata !== 32'd2) begin bad++; $display("FAIL autoreload_count: got %0d want 2", rdata); end
        clk1(1, 32'h00, 32'h0);
        clk1(1, 32'h0C, 32'h1);
    endtask

    task automatic test_w1c_collision();
        clk1(1, 32'h04, 32'd0);
        clk1(1, 32'h10, 32'd0);
        clk1(1, 32'h00, 32'h3);
        clk1(0, 32'h0C, 32'h0);
        clk1(1, 32'h0C, 32'h1);
        total++;
        if (rdata !== 32'd1) begin bad++; $display("FAIL w1c_collision: got %0d want 1", rdata); end
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL w1c_irq_off: got %b want 0", irq); end
        clk1(1, 32'h00, 32'h7);
        total++;
        if (irq !== 1'b1) begin bad++; $display("FAIL w1c_irq_on: got %b want 1", irq); end
        clk1(1, 32'h00, 32'h3);
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL w1c_irq_toggle: got %b want 0", irq); end
        clk1(1, 32'h00, 32'h0);
        clk1(1, 32'h0C, 32'h1);
        total++;
        if (rdata !== 32'd0) begin bad++; $display("FAIL w1c_clear: got %0d want 0", rdata); end
    endtask

    task automatic test_load_during_run();
        clk1(1, 32'h04, 32'd2);
        clk1(1, 32'h10, 32'd0);
        clk1(1, 32'h00, 32'h3);
        clk1(1, 32'h04, 32'd7);
        io_addr = 32'h08; #1;
        total++;
        if (rdata !== 32'd1) begin bad++; $display("FAIL loadrun_cur: got %0d want 1", rdata); end
        clk1(0, 32'h08, 32'd0);
        clk1(0, 32'h08, 32'd0);
        total++;
        if (rdata !== 32'd7) begin bad++; $display("FAIL loadrun_reload: got %0d want 7", rdata); end
        clk1(0, 32'h08, 32'd0);
        total++;
        if (rdata !== 32'd6) begin bad++; $display("FAIL loadrun_next: got %0d want 6", rdata); end
        clk1(1, 32'h00, 32'h0);
        clk1(1, 32'h0C, 32'h1);
    endtask

    task automatic test_unmapped();
        logic [31:0] a;
        clk1(1, 32'h08, 32'hFFFF);
        io_addr = 32'h08; #1;
        total++;
        if (rdata !== 32'd6) begin bad++; $display("FAIL count_ro: got %0h want 6", rdata); end
        clk1(1, 32'h00, 32'hFFFF_FFFE);
        total++;
        if (rdata !== 32'h6) begin bad++; $display("FAIL ctrl_bits: got %0h want 6", rdata); end
        clk1(1, 32'h14, 32'hDEAD_BEEF);
        io_addr = 32'h14; #1;
        total++;
        if (rdata !== 32'd0) begin bad++; $display("FAIL read_14: got %0h want 0", rdata); end
        io_addr = 32'hFC; #1;
        total++;
        if (rdata !== 32'd0) begin bad++; $display("FAIL read_fc: got %0h want 0", rdata); end
        for (int i = 0; i < 5; i++) begin
            a = 32'(i * 4);
            io_addr = a; #1;
            total++;
            if (rdata !== mRead(a)) begin
                bad++; $display("FAIL unmapped_side[%0h]: got %0h want %0h", a, rdata, mRead(a));
            end
        end
        clk1(1, 32'h00, 32'h0);
    endtask

    task automatic test_random();
        logic [31:0] a, d;
        logic        we;
        logic [5:0]  sel;
        for (int n = 0; n < 400; n++) begin
            we  = ($urandom_range(0, 3) == 0);
            sel = ($urandom_range(0, 9) == 0) ? 6'd63 : 6'($urandom_range(0, 5));
            a = $urandom();
            a[7:2] = sel;
            case (sel)
                6'd0:    d = {$urandom() & 32'hFFFF_FFF8, 29'd0 + 3'($urandom_range(0, 7))};
                6'd1:    d = 32'($urandom_range(0, 5));
                6'd4:    d = 32'($urandom_range(0, 3));
                default: d = $urandom();
            endcase
            clk1(we, a, d);
            a = $urandom();
            a[7:2] = 6'($urandom_range(0, 5));
            io_addr = a; #1;
            total++;
            if (rdata !== mRead(a) || irq !== (mExp & mCtrl[2])) begin
                bad++;
                $display("FAIL random@%0d addr=%0h: got rdata=%0h irq=%b want rdata=%0h irq=%b",
                         n, a, rdata, irq, mRead(a), mExp & mCtrl[2]);
            end
        end
    endtask

    task automatic test_reset_midrun();
        logic [31:0] a;
        clk1(1, 32'h00, 32'h0);
        clk1(1, 32'h04, 32'd0);
        clk1(1, 32'h10, 32'd0);
        clk1(1, 32'h00, 32'h5);
        clk1(0, 32'h00, 32'h0);
        clk1(1, 32'h04, 32'd9);
        clk1(1, 32'h00, 32'h5);
        for (int i = 0; i < 4; i++) clk1(0, 32'h08, 32'd0);
        total++;
        if (rdata !== 32'd5 || irq !== 1'b1) begin
            bad++; $display("FAIL midrun_setup: got count=%0d irq=%b want 5 1", rdata, irq);
        end
        rst_n = 1'b0; #1;
        modelReset();
        total++;
        if (rdata !== 32'd0 || irq !== 1'b0) begin
            bad++; $display("FAIL midrun_reset: got count=%0d irq=%b want 0 0", rdata, irq);
        end
        for (int i = 0; i < 5; i++) begin
            a = 32'(i * 4);
            io_addr = a; #1;
            total++;
            if (rdata !== 32'd0) begin
                bad++; $display("FAIL midrun_reg[%0h]: got %0h want 0", a, rdata);
            end
        end
        rst_n = 1'b1;
        clk1(0, 32'h00, 32'h0);
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_autoreload();
        test_w1c_collision();
        test_load_during_run();
        test_unmapped();
        test_random();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
